// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the multi-requester APB arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } arb_state_e;

    // Width needed to count 0..timeout inclusive; at least one bit.
    function automatic int unsigned tmo_cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_arch.svh
// Bus geometry shared by every APB block in this subsystem.
`ifndef APB_ARCH_SVH
`define APB_ARCH_SVH

`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`define STRB_SIZE  4

`endif

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ CPU-side requesters onto one APB master port.
`include "apb_arch.svh"

module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*`ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*`DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*`STRB_SIZE-1:0]     req_strb,
    output logic [NUM_REQ-1:0]                req_done,
    output logic [`DATA_WIDTH-1:0]            rsp_rdata,
    output logic                              rsp_err,
    output logic                              psel,
    output logic                              penable,
    output logic                              pwrite,
    output logic [`ADDR_WIDTH-1:0]            paddr,
    output logic [`DATA_WIDTH-1:0]            pwdata,
    output logic [`STRB_SIZE-1:0]             pstrb,
    input  logic                              pready,
    input  logic                              pslverr,
    input  logic [`DATA_WIDTH-1:0]            prdata
);

    localparam int unsigned AW = `ADDR_WIDTH;
    localparam int unsigned DW = `DATA_WIDTH;
    localparam int unsigned SW = `STRB_SIZE;
    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned CW = tmo_cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [AW-1:0]      paddr_q, paddr_d;
    logic [DW-1:0]      pwdata_q, pwdata_d;
    logic [SW-1:0]      pstrb_q, pstrb_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               timeout_hit;
    logic               complete;
    logic               launch;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] arb_grant;
    logic               arb_any;
    logic [PW-1:0]      sel_idx;
    logic [PW-1:0]      next_ptr;
    logic               sel_write;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic [SW-1:0]      sel_strb;

    // A counter that would reach TIMEOUT on this cycle's increment ends the access.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == StAccess) && (cnt_q == TMO_LAST);
    assign complete    = (state_q == StAccess) && (pready || timeout_hit);

    // Never re-grant the requester finishing now or the one still seeing its done pulse.
    assign eligible = req_valid & ~done_q & ~(complete ? grant_q : '0);
    assign arb_any  = |arb_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (eligible),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_idx = PW'(i);
            end
        end
    end

    assign next_ptr  = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    assign sel_write = req_write[sel_idx];
    assign sel_addr  = req_addr[sel_idx*AW +: AW];
    assign sel_wdata = req_wdata[sel_idx*DW +: DW];
    assign sel_strb  = req_strb[sel_idx*SW +: SW];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        done_d   = '0;
        rdata_d  = '0;
        err_d    = 1'b0;
        launch   = 1'b0;

        unique case (state_q)
            StIdle: begin
                launch = arb_any;
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (cnt_q != TMO_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (complete) begin
                    done_d  = grant_q;
                    rdata_d = pwrite_q ? '0 : prdata;
                    err_d   = pready ? pslverr : 1'b1;
                    if (arb_any) begin
                        launch = 1'b1;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (launch) begin
            state_d  = StSetup;
            grant_d  = arb_grant;
            ptr_d    = next_ptr;
            cnt_d    = '0;
            pwrite_d = sel_write;
            paddr_d  = sel_addr;
            pwdata_d = sel_wdata;
            pstrb_d  = sel_write ? sel_strb : '0;
        end

        psel_d    = (state_d != StIdle);
        penable_d = (state_d == StAccess);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign req_done  = done_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Scoreboard bench for apb_arbiter: directed requests, APB slave model, response monitor.
module tb_apb_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned TMO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_write, req_done;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*SW-1:0]  req_strb;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              psel, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [SW-1:0]     pstrb;
    logic              pready, pslverr;
    logic [DW-1:0]     prdata;

    always #5 clk = ~clk;

    apb_arbiter #(
        .NUM_REQ (NR),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_done  (req_done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pready    (pready),
        .pslverr   (pslverr),
        .prdata    (prdata)
    );

    typedef struct {
        logic [NR-1:0] done;
        logic [DW-1:0] rdata;
        logic          err;
        bit            chk_data;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n;
    int   slave_wait  = 0;
    bit   slave_never = 1'b0;
    bit   slave_err   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'hA5A5A5A5;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic push(input logic [NR-1:0] d, input logic [DW-1:0] r, input logic er,
                        input bit cd, input int c);
        exp_t x;
        x.done = d; x.rdata = r; x.err = er; x.chk_data = cd; x.cyc = c;
        exp_q.push_back(x);
    endtask

    task automatic at_cyc(input int c);
        forever begin
            @(negedge clk);
            if (cyc >= c) break;
        end
    endtask

    task automatic issue(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW]  = s;
        req_valid[i]          = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"},      psel,      0);
        chk({tag, "_penable"},   penable,   0);
        chk({tag, "_pwrite"},    pwrite,    0);
        chk({tag, "_paddr"},     paddr,     0);
        chk({tag, "_pwdata"},    pwdata,    0);
        chk({tag, "_pstrb"},     pstrb,     0);
        chk({tag, "_req_done"},  req_done,  0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"},   rsp_err,   0);
    endtask

    // APB slave: pready after slave_wait ACCESS cycles unless slave_never is set.
    initial begin
        int acc;
        acc = 0; pready = 1'b0; pslverr = 1'b0; prdata = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                if (!slave_never && acc >= slave_wait) begin
                    pready = 1'b1; prdata = slave_data(paddr); pslverr = slave_err;
                end else begin
                    pready = 1'b0; prdata = 32'hDEADBEEF; pslverr = 1'b0;
                end
                acc++;
            end else begin
                pready = 1'b0; prdata = 32'hDEADBEEF; pslverr = 1'b0; acc = 0;
            end
        end
    end

    // Requesters hold req_valid through their done cycle, dropping it just after.
    initial begin
        logic [NR-1:0] pend;
        forever begin
            @(negedge clk);
            pend = req_done;
            if (pend != '0) begin
                @(posedge clk);
                #1;
                req_valid = req_valid & ~pend;
            end
        end
    end

    // Response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (req_done !== '0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got req_done=%b, expected none (cycle %0d)",
                             req_done, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_grant", req_done, e.done);
                    chk("done_cycle", cyc, e.cyc);
                    if (e.chk_data) chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_write = '0;
        req_addr = '0; req_wdata = '0; req_strb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(posedge clk);

        // Contention: all four at once, grant order 0..3 with no idle gap.
        @(posedge clk); #1; n = cyc;
        for (int i = 0; i < 4; i++) issue(i, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'hF);
        push(4'b0001, 32'h0100FEFF, 1'b0, 1'b1, n + 3);
        push(4'b0010, 32'h0104FEFB, 1'b0, 1'b1, n + 5);
        push(4'b0100, 32'h0108FEF7, 1'b0, 1'b1, n + 7);
        push(4'b1000, 32'h010CFEF3, 1'b0, 1'b1, n + 9);
        for (int k = 1; k <= 8; k++) begin
            at_cyc(n + k);
            chk("rr_psel", psel, 1);
            chk("rr_penable", penable, (k % 2 == 0) ? 1 : 0);
            chk("rr_read_pstrb", pstrb, 0);
        end
        at_cyc(n + 9);
        chk("rr_idle_psel", psel, 0);
        repeat (2) @(posedge clk);

        // Single read, latency N+3.
        @(posedge clk); #1; n = cyc;
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        push(4'b0001, 32'hA5A5A5A5, 1'b0, 1'b1, n + 3);
        at_cyc(n + 1);
        chk("rd_setup_psel", psel, 1);
        chk("rd_setup_penable", penable, 0);
        chk("rd_paddr", paddr, 32'h10);
        chk("rd_pwrite", pwrite, 0);
        chk("rd_pstrb", pstrb, 0);
        at_cyc(n + 2);
        chk("rd_access_penable", penable, 1);
        at_cyc(n + 4);
        chk("rd_idle_psel", psel, 0);
        repeat (2) @(posedge clk);

        // No re-grant while req_valid[1] lingers through its done cycle.
        @(posedge clk); #1; n = cyc;
        issue(1, 1'b0, 32'h40, 32'h0, 4'h0);
        push(4'b0010, 32'h0040FFBF, 1'b0, 1'b1, n + 3);
        for (int k = 4; k <= 6; k++) begin
            at_cyc(n + k);
            chk("no_regrant_psel", psel, 0);
        end

        // Write with three wait states; completes on the timeout-limit cycle.
        slave_wait = 3;
        @(posedge clk); #1; n = cyc;
        issue(3, 1'b1, 32'h20, 32'h12345678, 4'hF);
        push(4'b1000, 32'h0, 1'b0, 1'b1, n + 6);
        for (int k = 1; k <= 5; k++) begin
            at_cyc(n + k);
            chk("ws_paddr", paddr, 32'h20);
            chk("ws_pwdata", pwdata, 32'h12345678);
            chk("ws_pstrb", pstrb, 4'hF);
            chk("ws_pwrite", pwrite, 1);
            if (k == 2) begin
                req_addr[3*AW +: AW] = 32'h999; req_wdata[3*DW +: DW] = 32'h0;
                req_strb[3*SW +: SW] = 4'h0;    req_write[3] = 1'b0;
            end
        end
        at_cyc(n + 6);
        slave_wait = 0;
        repeat (2) @(posedge clk);

        // Timeout: no pready, completes after four ACCESS cycles with error.
        slave_never = 1'b1;
        @(posedge clk); #1; n = cyc;
        issue(2, 1'b0, 32'h30, 32'h0, 4'h0);
        push(4'b0100, 32'h0, 1'b1, 1'b0, n + 6);
        at_cyc(n + 5);
        chk("tmo_penable", penable, 1);
        at_cyc(n + 6);
        chk("tmo_idle_psel", psel, 0);
        slave_never = 1'b0;
        repeat (2) @(posedge clk);

        // Slave error with pready after one wait state.
        slave_err = 1'b1; slave_wait = 1;
        @(posedge clk); #1; n = cyc;
        issue(0, 1'b1, 32'h44, 32'hA0A0A0A0, 4'h3);
        push(4'b0001, 32'h0, 1'b1, 1'b1, n + 4);
        at_cyc(n + 3);
        chk("err_pstrb", pstrb, 4'h3);
        at_cyc(n + 5);
        slave_err = 1'b0; slave_wait = 0;
        repeat (2) @(posedge clk);

        // Reset mid-ACCESS aborts; pending requester 2 then wins from pointer 0.
        slave_wait = 10;
        @(posedge clk); #1; n = cyc;
        issue(0, 1'b1, 32'h50, 32'hCAFEF00D, 4'h3);
        at_cyc(n + 3);
        chk("rstmid_penable", penable, 1);
        chk("rstmid_pwrite", pwrite, 1);
        rst = 1'b1;
        req_valid[0] = 1'b0;
        issue(2, 1'b0, 32'h60, 32'h0, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0; slave_wait = 0;
        push(4'b0100, 32'h0060FF9F, 1'b0, 1'b1, n + 7);
        at_cyc(n + 4);
        chk_all_zero("rstmid");
        at_cyc(n + 5);
        chk("post_rst_psel", psel, 1);
        chk("post_rst_paddr", paddr, 32'h60);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
